// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction-memory address and registers
// the fetched word into IF/ID. Per-edge priority is redirect > stall > advance.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchAddress,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] RegTarget,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic [31:0] IDPCAddResult,
  output logic [31:0] IDInstruction,
  output logic        IDValid,
  output logic        AlignErr,
  output logic [31:0] Debug_Program_Counter,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  typedef struct packed {
    logic [31:0] pcAddResult;
    logic [31:0] instr;
    logic        valid;
  } ifIdT;

  logic [31:0] pc;
  logic [31:0] pcPlus;
  logic [31:0] redirTarget;
  logic        redirect;
  ifIdT        ifId;

  assign pcPlus   = pc + PC_STEP;
  assign redirect = (PCSrc != 2'b00);

  always_comb begin
    redirTarget = pcPlus;
    case (PCSrc)
      2'b01:   redirTarget = BranchAddress;
      2'b10:   redirTarget = JumpTarget;
      2'b11:   redirTarget = RegTarget;
      default: redirTarget = pcPlus;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc         <= RESET_PC;
      ifId       <= '0;
      AlignErr   <= 1'b0;
      FetchCount <= '0;
      StallCount <= '0;
    end else if (redirect) begin
      // Low bits are forced clear; a misaligned target is only flagged.
      pc   <= {redirTarget[31:2], 2'b00};
      ifId <= '0;
      if (redirTarget[1:0] != 2'b00) AlignErr <= 1'b1;
    end else if (Stall) begin
      if (StallCount != 32'hFFFF_FFFF) StallCount <= StallCount + 32'd1;
    end else begin
      pc               <= pcPlus;
      ifId.pcAddResult <= pcPlus;
      ifId.instr       <= IMemData;
      ifId.valid       <= 1'b1;
      if (FetchCount != 32'hFFFF_FFFF) FetchCount <= FetchCount + 32'd1;
    end
  end

  assign IMemAddr              = pc;
  assign Debug_Program_Counter = pc;
  assign IDPCAddResult         = ifId.pcAddResult;
  assign IDInstruction         = ifId.instr;
  assign IDValid               = ifId.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// redirect/stall traffic checked against a behavioural model.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] BranchAddress = '0, JumpTarget = '0, RegTarget = '0;
  logic [31:0] IMemAddr, IMemData, IDPCAddResult, IDInstruction;
  logic        IDValid, AlignErr;
  logic [31:0] Debug_Program_Counter, FetchCount, StallCount;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] mPc, mIdPc, mIdInstr, mFetch, mStall;
  logic        mIdValid, mAlign;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign IMemData = memWord(IMemAddr);

  fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc),
    .BranchAddress(BranchAddress), .JumpTarget(JumpTarget), .RegTarget(RegTarget),
    .IMemAddr(IMemAddr), .IMemData(IMemData),
    .IDPCAddResult(IDPCAddResult), .IDInstruction(IDInstruction), .IDValid(IDValid),
    .AlignErr(AlignErr), .Debug_Program_Counter(Debug_Program_Counter),
    .FetchCount(FetchCount), .StallCount(StallCount)
  );

  task automatic modelReset();
    mPc = 32'h0; mIdPc = 0; mIdInstr = 0; mIdValid = 0; mAlign = 0; mFetch = 0; mStall = 0;
  endtask

  // Apply one clock edge to both model and DUT, then sample 1 time unit later.
  task automatic step();
    logic [31:0] tgt;
    if (PCSrc != 2'b00) begin
      tgt = (PCSrc == 2'b01) ? BranchAddress : (PCSrc == 2'b10) ? JumpTarget : RegTarget;
      if (tgt % 4 != 0) mAlign = 1;
      mPc = tgt - (tgt % 4);
      mIdPc = 0; mIdInstr = 0; mIdValid = 0;
    end else if (Stall) begin
      if (mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
    end else begin
      mIdInstr = memWord(mPc);
      mIdPc = mPc + 4;
      mPc = mPc + 4;
      mIdValid = 1;
      if (mFetch != 32'hFFFF_FFFF) mFetch = mFetch + 1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", IMemAddr, 32'h0); end
    checks++; if (IDValid !== 1'b0 || IDInstruction !== 32'h0 || IDPCAddResult !== 32'h0) begin
      errors++; $display("FAIL reset_ifid got v=%b i=%h p=%h exp 0", IDValid, IDInstruction, IDPCAddResult); end
    checks++; if (FetchCount !== 0 || StallCount !== 0 || AlignErr !== 1'b0) begin
      errors++; $display("FAIL reset_cnt got f=%0d s=%0d a=%b exp 0", FetchCount, StallCount, AlignErr); end
  endtask

  task automatic test_sequential();
    Reset = 1'b1;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (IMemAddr !== 32'(4*i)) begin errors++; $display("FAIL seq_addr%0d got %h exp %h", i, IMemAddr, 32'(4*i)); end
      step();
      checks++; if (IDPCAddResult !== 32'(4*(i+1)) || IDValid !== 1'b1 || IDInstruction !== memWord(32'(4*i))) begin
        errors++; $display("FAIL seq_id%0d got p=%h v=%b i=%h exp p=%h v=1 i=%h", i, IDPCAddResult, IDValid,
                           IDInstruction, 32'(4*(i+1)), memWord(32'(4*i))); end
    end
    checks++; if (FetchCount !== 32'd4) begin errors++; $display("FAIL seq_fetchcount got %0d exp 4", FetchCount); end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = 32'h10;
    Stall = 1'b1;
    repeat (3) step();
    checks++; if (IMemAddr !== held) begin errors++; $display("FAIL stall_pc got %h exp %h", IMemAddr, held); end
    checks++; if (IDPCAddResult !== 32'h10 || IDInstruction !== memWord(32'hC) || IDValid !== 1'b1) begin
      errors++; $display("FAIL stall_frozen got p=%h i=%h v=%b exp p=10 i=%h v=1", IDPCAddResult, IDInstruction,
                         IDValid, memWord(32'hC)); end
    checks++; if (StallCount !== 32'd3 || FetchCount !== 32'd4) begin
      errors++; $display("FAIL stall_counts got s=%0d f=%0d exp s=3 f=4", StallCount, FetchCount); end
    Stall = 1'b0;
    step();
    checks++; if (IDInstruction !== memWord(held) || IDPCAddResult !== held + 4) begin
      errors++; $display("FAIL stall_resume got i=%h p=%h exp i=%h p=%h", IDInstruction, IDPCAddResult,
                         memWord(held), held + 4); end
  endtask

  task automatic test_branch_stall();
    PCSrc = 2'b01; BranchAddress = 32'h40; Stall = 1'b1;
    step();
    checks++; if (IMemAddr !== 32'h40 || IDValid !== 1'b0 || IDInstruction !== 32'h0) begin
      errors++; $display("FAIL branch_squash got pc=%h v=%b i=%h exp pc=40 v=0 i=0", IMemAddr, IDValid, IDInstruction); end
    checks++; if (StallCount !== 32'd3) begin errors++; $display("FAIL branch_stallcount got %0d exp 3", StallCount); end
    PCSrc = 2'b00; Stall = 1'b0;
    step();
    checks++; if (IDPCAddResult !== 32'h44 || IDInstruction !== memWord(32'h40) || IDValid !== 1'b1) begin
      errors++; $display("FAIL branch_arrive got p=%h i=%h v=%b exp p=44", IDPCAddResult, IDInstruction, IDValid); end
  endtask

  task automatic test_wrap();
    PCSrc = 2'b10; JumpTarget = 32'hFFFF_FFFC;
    step();
    PCSrc = 2'b00;
    step();
    checks++; if (IMemAddr !== 32'h0 || IDPCAddResult !== 32'h0 || IDValid !== 1'b1) begin
      errors++; $display("FAIL wrap got pc=%h p=%h v=%b exp pc=0 p=0 v=1", IMemAddr, IDPCAddResult, IDValid); end
    checks++; if (AlignErr !== 1'b0) begin errors++; $display("FAIL wrap_noflag got %b exp 0", AlignErr); end
  endtask

  task automatic test_align();
    PCSrc = 2'b11; RegTarget = 32'h103;
    step();
    checks++; if (IMemAddr !== 32'h100 || AlignErr !== 1'b1) begin
      errors++; $display("FAIL align_set got pc=%h a=%b exp pc=100 a=1", IMemAddr, AlignErr); end
    PCSrc = 2'b10; JumpTarget = 32'h200;
    step();
    checks++; if (Debug_Program_Counter !== 32'h200 || IDValid !== 1'b0) begin
      errors++; $display("FAIL jump_b2b got pc=%h v=%b exp pc=200 v=0", Debug_Program_Counter, IDValid); end
    PCSrc = 2'b00;
    repeat (2) step();
    checks++; if (AlignErr !== 1'b1 || IMemAddr !== 32'h208) begin
      errors++; $display("FAIL align_sticky got a=%b pc=%h exp a=1 pc=208", AlignErr, IMemAddr); end
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: PCSrc = 2'b01;
        1: PCSrc = 2'b10;
        2: PCSrc = 2'b11;
        default: PCSrc = 2'b00;
      endcase
      Stall = ($urandom_range(0, 3) == 0);
      BranchAddress = $urandom;
      JumpTarget = $urandom & 32'hFFFF_FFFC;
      RegTarget = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step();
      bad = 0;
      if (IMemAddr !== mPc || Debug_Program_Counter !== mPc) bad = 1;
      if (IDPCAddResult !== mIdPc || IDInstruction !== mIdInstr || IDValid !== mIdValid) bad = 1;
      if (AlignErr !== mAlign || FetchCount !== mFetch || StallCount !== mStall) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random%0d got pc=%h p=%h i=%h v=%b a=%b f=%0d s=%0d exp pc=%h p=%h i=%h v=%b a=%b f=%0d s=%0d",
                 n, IMemAddr, IDPCAddResult, IDInstruction, IDValid, AlignErr, FetchCount, StallCount,
                 mPc, mIdPc, mIdInstr, mIdValid, mAlign, mFetch, mStall);
      end
    end
    PCSrc = 2'b00; Stall = 1'b0;
  endtask

  task automatic test_async_reset();
    Stall = 1'b1;
    step();
    #2 Reset = 1'b0;
    #1;
    checks++; if (IMemAddr !== 32'h0 || IDValid !== 1'b0 || IDInstruction !== 32'h0 || IDPCAddResult !== 32'h0) begin
      errors++; $display("FAIL async_reset_state got pc=%h v=%b i=%h p=%h exp 0", IMemAddr, IDValid, IDInstruction,
                         IDPCAddResult); end
    checks++; if (FetchCount !== 0 || StallCount !== 0 || AlignErr !== 1'b0) begin
      errors++; $display("FAIL async_reset_cnt got f=%0d s=%0d a=%b exp 0", FetchCount, StallCount, AlignErr); end
    @(posedge Clk); #1;
    Reset = 1'b1; Stall = 1'b0;
    modelReset();
    step();
    checks++; if (IDInstruction !== memWord(32'h0) || IDPCAddResult !== 32'h4 || IMemAddr !== 32'h4) begin
      errors++; $display("FAIL async_reset_refetch got i=%h p=%h pc=%h exp i=%h p=4 pc=4", IDInstruction,
                         IDPCAddResult, IMemAddr, memWord(32'h0)); end
  endtask

  initial begin
    #12;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_align();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
